// File: rtl/rvj1_data_bus_router.sv
// rvj1_data_bus_router
//
// Purpose: routes rvj1 core data-port requests by address to one of two
// slaves (slave 0 = data RAM, slave 1 = peripheral window). Unmapped
// addresses are accepted immediately and answered with an internally
// generated error response. Responses return to the core strictly in request
// order; a small FIFO of target IDs remembers who owns each outstanding
// transaction.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   m_req_*                  core request channel (addr/data/strobe/write/valid/ready)
//   m_rsp_*                  core response channel (data/error/valid/ready)
//   s0_req_*, s1_req_*       forwarded request channels (addr/data/strobe/write broadcast)
//   s0_rsp_*, s1_rsp_*       slave response channels
//   outstanding_o            number of transactions awaiting a response
//   spurious_rsp_o           sticky flag: a slave responded while nothing was outstanding
module rvj1_data_bus_router #(
    parameter int              XLEN            = 32,
    parameter int              NBYTES          = XLEN / 8,
    parameter logic [XLEN-1:0] S0_BASE         = 32'h8020_0000,
    parameter logic [XLEN-1:0] S0_SIZE_BYTES   = 32'h0020_0000,
    parameter logic [XLEN-1:0] S1_BASE         = 32'h9000_0000,
    parameter logic [XLEN-1:0] S1_SIZE_BYTES   = 32'h0000_1000,
    parameter int              MAX_OUTSTANDING = 2,
    localparam int             CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic [XLEN-1:0]   m_req_addr_i,
    input  logic [XLEN-1:0]   m_req_data_i,
    input  logic [NBYTES-1:0] m_req_strobe_i,
    input  logic              m_req_write_i,
    input  logic              m_req_valid_i,
    output logic              m_req_ready_o,
    output logic [XLEN-1:0]   m_rsp_data_o,
    output logic              m_rsp_error_o,
    output logic              m_rsp_valid_o,
    input  logic              m_rsp_ready_i,

    output logic [XLEN-1:0]   s0_req_addr_o,
    output logic [XLEN-1:0]   s0_req_data_o,
    output logic [NBYTES-1:0] s0_req_strobe_o,
    output logic              s0_req_write_o,
    output logic              s0_req_valid_o,
    input  logic              s0_req_ready_i,
    input  logic [XLEN-1:0]   s0_rsp_data_i,
    input  logic              s0_rsp_error_i,
    input  logic              s0_rsp_valid_i,
    output logic              s0_rsp_ready_o,

    output logic [XLEN-1:0]   s1_req_addr_o,
    output logic [XLEN-1:0]   s1_req_data_o,
    output logic [NBYTES-1:0] s1_req_strobe_o,
    output logic              s1_req_write_o,
    output logic              s1_req_valid_o,
    input  logic              s1_req_ready_i,
    input  logic [XLEN-1:0]   s1_rsp_data_i,
    input  logic              s1_rsp_error_i,
    input  logic              s1_rsp_valid_i,
    output logic              s1_rsp_ready_o,

    output logic [CW-1:0]     outstanding_o,
    output logic              spurious_rsp_o
);

    typedef enum logic [1:0] {
        TGT_S0  = 2'd0,
        TGT_S1  = 2'd1,
        TGT_ERR = 2'd2
    } target_t;

    // A depth-1 FIFO still needs a one-bit pointer to keep the index legal.
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN:0] off0;
    logic [XLEN:0] off1;
    logic          hit0;
    logic          hit1;
    target_t       sel;
    logic          sel_ready;

    target_t       id_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    target_t       head;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Window decode: the extra top bit makes an address below the base
    // produce a huge offset instead of wrapping into the window.
    assign off0 = {1'b0, m_req_addr_i} - {1'b0, S0_BASE};
    assign off1 = {1'b0, m_req_addr_i} - {1'b0, S1_BASE};
    assign hit0 = off0 < {1'b0, S0_SIZE_BYTES};
    assign hit1 = off1 < {1'b0, S1_SIZE_BYTES};

    // Slave 0 takes priority if the windows were ever configured to overlap;
    // anything matching neither window is answered locally with an error.
    always_comb begin
        sel       = TGT_ERR;
        sel_ready = 1'b1;
        if (hit0) begin
            sel       = TGT_S0;
            sel_ready = s0_req_ready_i;
        end else if (hit1) begin
            sel       = TGT_S1;
            sel_ready = s1_req_ready_i;
        end
    end

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = id_fifo[rd_ptr];

    // Reset gates the handshake explicitly so nothing is launched while the
    // slaves (which share this reset) are being cleared.
    assign m_req_ready_o  = rstn_i & ~full & sel_ready;
    assign s0_req_valid_o = rstn_i & m_req_valid_i & (sel == TGT_S0) & ~full;
    assign s1_req_valid_o = rstn_i & m_req_valid_i & (sel == TGT_S1) & ~full;

    assign s0_req_addr_o   = m_req_addr_i;
    assign s0_req_data_o   = m_req_data_i;
    assign s0_req_strobe_o = m_req_strobe_i;
    assign s0_req_write_o  = m_req_write_i;
    assign s1_req_addr_o   = m_req_addr_i;
    assign s1_req_data_o   = m_req_data_i;
    assign s1_req_strobe_o = m_req_strobe_i;
    assign s1_req_write_o  = m_req_write_i;

    // Response mux driven by the oldest outstanding ID. Only the head slave
    // sees ready, so a slave that answers early simply holds its response.
    always_comb begin
        m_rsp_valid_o  = 1'b0;
        m_rsp_data_o   = '0;
        m_rsp_error_o  = 1'b0;
        s0_rsp_ready_o = 1'b0;
        s1_rsp_ready_o = 1'b0;
        if (!empty) begin
            case (head)
                TGT_S0: begin
                    m_rsp_valid_o  = s0_rsp_valid_i;
                    m_rsp_data_o   = s0_rsp_data_i;
                    m_rsp_error_o  = s0_rsp_error_i;
                    s0_rsp_ready_o = m_rsp_ready_i;
                end
                TGT_S1: begin
                    m_rsp_valid_o  = s1_rsp_valid_i;
                    m_rsp_data_o   = s1_rsp_data_i;
                    m_rsp_error_o  = s1_rsp_error_i;
                    s1_rsp_ready_o = m_rsp_ready_i;
                end
                default: begin
                    m_rsp_valid_o = 1'b1;
                    m_rsp_error_o = 1'b1;
                end
            endcase
        end
    end

    assign push = m_req_valid_i & m_req_ready_o;
    assign pop  = m_rsp_valid_o & m_rsp_ready_i;

    // ID FIFO. Full is judged on the count before this cycle's pop, so a
    // full FIFO never accepts a request in the same cycle it drains one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo[i] <= TGT_ERR;
            end
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky protocol-violation flag: any slave response while nothing is
    // outstanding can never be delivered, so record it until reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            spurious_rsp_o <= 1'b0;
        end else if (empty && (s0_rsp_valid_i || s1_rsp_valid_i)) begin
            spurious_rsp_o <= 1'b1;
        end
    end

    assign outstanding_o = count;

endmodule

// File: doc/rvj1_data_bus_router.md
Name: rvj1_data_bus_router

Overview:
Sits between the rvj1_top data port and its data-side slaves. Routes each core data request by address to one of two slaves: slave 0 is the data RAM (bytewrite_sram_wrap), slave 1 is a peripheral window such as sim control, tohost or UART. Requests to unmapped addresses complete with an internally generated error response. Responses return to the core strictly in request order, tracked by an ID FIFO of outstanding transactions.

Parameters:
S0_BASE, 32'h8020_0000, slave 0 base byte address
S0_SIZE_BYTES, 32'h0020_0000, slave 0 window size
S1_BASE, 32'h9000_0000, slave 1 base byte address
S1_SIZE_BYTES, 32'h0000_1000, slave 1 window size
MAX_OUTSTANDING, 2, ID FIFO depth, >=1

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m_req_addr_i / m_req_data_i  in  XLEN  core request address / write data
m_req_strobe_i  in  NBYTES  byte strobes
m_req_write_i / m_req_valid_i  in  1  write flag / request valid
m_req_ready_o  out  1  request accepted
m_rsp_data_o  out  XLEN  response data
m_rsp_error_o / m_rsp_valid_o  out  1  response error / valid
m_rsp_ready_i  in  1  core accepts response
sN_req_addr_o / sN_req_data_o  out  XLEN  (N=0,1) forwarded address (full, unmodified) / data
sN_req_strobe_o  out  NBYTES  forwarded strobes
sN_req_write_o / sN_req_valid_o  out  1  forwarded write / valid
sN_req_ready_i  in  1  slave ready
sN_rsp_data_i  in  XLEN  slave response data
sN_rsp_error_i / sN_rsp_valid_i  in  1  slave response error / valid
sN_rsp_ready_o  out  1  router accepts slave response
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  FIFO occupancy
spurious_rsp_o  out  1  sticky: slave asserted rsp_valid with no matching head entry

Behaviour:
- Decode (combinational): hit_N = (addr - SN_BASE) < SN_SIZE_BYTES, computed in 33-bit unsigned arithmetic so wrap-around cannot alias. If both windows hit, S0 wins. If neither hits, the target is ERR.
- Request path, zero latency:
  - sN_req_valid_o = m_req_valid_i & sel==N & !full.
  - Address, data, strobe and write go to both slaves unconditionally.
  - m_req_ready_o = !full & (sel==S0 ? s0_req_ready_i : sel==S1 ? s1_req_ready_i : 1).
- Push: on m_req fire, the target ID (S0/S1/ERR) is written to the FIFO tail. Full is taken from the pre-pop count, so there is no push-through-pop bypass when full.
- Response path, zero latency, in order:
  - Head ID = H, valid only when FIFO is non-empty.
  - H==SN: m_rsp_valid_o = sN_rsp_valid_i; data and error are muxed from slave N; sN_rsp_ready_o = m_rsp_ready_i.
  - H==ERR: m_rsp_valid_o=1, m_rsp_data_o=0, m_rsp_error_o=1, with no slave involvement.
  - A slave that is not at the head sees rsp_ready_o=0 and must hold its response.
- Pop: on m_rsp fire. A simultaneous push and pop leaves the count unchanged and the FIFO pointers both advance.
- spurious_rsp_o: set when sN_rsp_valid_i=1 while the FIFO is empty. Cleared only by reset.
- Reset (async assert, sync release):
  - FIFO empties; outstanding_o=0; spurious_rsp_o=0.
  - Consequently m_rsp_valid_o=0 and all sN_rsp_ready_o=0.
  - While rstn_i=0, m_req_ready_o=0 and sN_req_valid_o=0, gated explicitly.
  - Reset mid-transaction drops all in-flight IDs; slaves share the same reset.
- Responses are never reordered, duplicated or dropped outside reset. An ERR entry never stalls on slaves.
- Misalignment and strobe legality are not checked by the router; they pass through unchanged.

Test Plan:
- Single read to 0x8020_0010 with S0 returning 0xDEAD_BEEF one cycle later -> s0 valid only; m_rsp_data=0xDEAD_BEEF, error=0; outstanding goes 1 then 0.
- Write to 0x9000_0004 with strobe 4'b0011 -> routed to s1 only; s0_req_valid stays 0; strobe is forwarded as 4'b0011.
- Read to 0x0000_1000 (unmapped) -> accepted in the same cycle; next response is data 0, error 1; no slave valid is asserted.
- Back-to-back S1 then S0 with MAX_OUTSTANDING=2, where S0 responds first -> s0_rsp_ready held 0 until the S1 response pops; core sees S1 data then S0 data; a third request is stalled (m_req_ready=0) while outstanding=2.
- Assert rstn_i with two requests outstanding -> outstanding_o=0 immediately; m_rsp_valid=0; a post-reset read to S0 completes normally.
- S0 asserts rsp_valid with the FIFO empty -> spurious_rsp_o rises the next cycle and stays 1 until reset; no m_rsp_valid is produced.
